secuenciador_estado: RTL

- Sequencing FSM that generates the 3-bit state code consumed by the state decoder (ESTADO_DEC).
- ESTADO_DEC drives its output 0 for codes 0-2 (setup phase) and 1 for codes 3-7 (active phase).
- Walks a timed sequence IDLE→ARM→WAIT→START→RUN→DONE on a START request, with ABORT and an ACK handshake.
- Exports the code plus the matching phase flag, busy, and done/count status.

---
 rtl/secuenciador_estado_if.sv | 31 +++
 rtl/secuenciador_estado.sv | 104 ++++++++++
 2 files changed

// File: rtl/secuenciador_estado_if.sv
// Handshake and status bundle for the state sequencer.
//   master : drives START/ABORT/ACK, observes the status outputs
//   slave  : the sequencer itself; samples requests, drives the status
//   START, ABORT, ACK         requests towards the sequencer
//   ESTADO[2:0]               registered state code (feeds ESTADO_DEC.IN)
//   ACTIVO, BUSY, DONE        combinational decodes of ESTADO
//   CUENTA[CW-1:0]            registered dwell counter
interface secuenciador_estado_if #(
   parameter int unsigned CW = 4
);

   logic          START;
   logic          ABORT;
   logic          ACK;
   logic [2:0]    ESTADO;
   logic          ACTIVO;
   logic          BUSY;
   logic          DONE;
   logic [CW-1:0] CUENTA;

   modport master (
      output START, ABORT, ACK,
      input  ESTADO, ACTIVO, BUSY, DONE, CUENTA
   );

   modport slave (
      input  START, ABORT, ACK,
      output ESTADO, ACTIVO, BUSY, DONE, CUENTA
   );

endinterface

// File: rtl/secuenciador_estado.sv
// Timed sequencing FSM producing the 3-bit state code consumed by ESTADO_DEC.
// Walks IDLE -> ARM -> WAIT(T_WAIT cycles) -> START -> RUN(T_RUN cycles) -> DONE,
// returning to IDLE on ACK (in DONE), on ABORT (any state), or from an
// illegal code (6/7).
//   CLK    system clock, rising edge
//   RESET  synchronous, active-low reset
//   bus    slave side of secuenciador_estado_if (requests in, status out)
module secuenciador_estado #(
   parameter int unsigned T_WAIT = 4,
   parameter int unsigned T_RUN  = 8,
   parameter int unsigned CW     = 4
) (
   input  logic                 CLK,
   input  logic                 RESET,
   secuenciador_estado_if.slave bus
);

   // Terminal counts, truncated to CW bits so T = 2^CW wraps to all-ones.
   localparam logic [CW-1:0] WAIT_LAST = CW'(T_WAIT - 1);
   localparam logic [CW-1:0] RUN_LAST  = CW'(T_RUN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_WAIT  = 3'd2,
      S_START = 3'd3,
      S_RUN   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   logic [2:0]    estado_q;
   logic [CW-1:0] cuenta_q;
   state_t        state_cur;
   state_t        state_next;
   logic [CW-1:0] cuenta_next;

   // Raw register kept as plain bits so codes 6/7 remain representable.
   assign state_cur = state_t'(estado_q);

   // State and counter registers.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         estado_q <= 3'd0;
         cuenta_q <= '0;
      end else begin
         estado_q <= 3'(state_next);
         cuenta_q <= cuenta_next;
      end
   end

   // Next-state and next-count logic; ABORT overrides the normal transition.
   always_comb begin
      state_next  = S_IDLE;
      cuenta_next = '0;

      case (state_cur)
         S_IDLE: begin
            state_next = bus.START ? S_ARM : S_IDLE;
         end
         S_ARM: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (cuenta_q == WAIT_LAST) begin
               state_next = S_START;
            end else begin
               state_next  = S_WAIT;
               cuenta_next = cuenta_q + CW'(1);
            end
         end
         S_START: begin
            state_next = S_RUN;
         end
         S_RUN: begin
            if (cuenta_q == RUN_LAST) begin
               state_next = S_DONE;
            end else begin
               state_next  = S_RUN;
               cuenta_next = cuenta_q + CW'(1);
            end
         end
         S_DONE: begin
            state_next = bus.ACK ? S_IDLE : S_DONE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // In IDLE this also suppresses a simultaneous START.
      if (bus.ABORT) begin
         state_next  = S_IDLE;
         cuenta_next = '0;
      end
   end

   // Status decodes; ACTIVO mirrors ESTADO_DEC, including codes 6/7.
   assign bus.ESTADO = estado_q;
   assign bus.CUENTA = cuenta_q;
   assign bus.ACTIVO = (estado_q >= 3'd3);
   assign bus.BUSY   = (estado_q != 3'd0);
   assign bus.DONE   = (estado_q == 3'(S_DONE));

endmodule
